dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
Controller that turns the team's simple dual-port RAM (ADDR_WIDTH/DATA_WIDTH, one clock, registered read on each port) into a first-word-fall-through stream FIFO.
- RAM port A is the write port; RAM port B is the read port.
- A 2-entry output buffer absorbs the 1-cycle RAM read latency, so the FIFO sustains one word per cycle in and out.
- Sits between an upstream valid/ready producer and a downstream valid/ready consumer. The dpram instance sits beside it.

Parameters:
ADDR_WIDTH, 6, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH; must be >= 2
DATA_WIDTH, 8, word width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream word valid
s_ready  out  1  FIFO can accept a word
s_data  in  DATA_WIDTH  upstream word
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts the word
m_data  out  DATA_WIDTH  output word (head of output buffer)
count  out  ADDR_WIDTH+1  total words held (RAM + in-flight read + output buffer)
ram_we_a  out  1  to dpram we_a
ram_addr_a  out  ADDR_WIDTH  to dpram addr_a
ram_din_a  out  DATA_WIDTH  to dpram din_a
ram_we_b  out  1  to dpram we_b, tied 0
ram_addr_b  out  ADDR_WIDTH  to dpram addr_b
ram_din_b  out  DATA_WIDTH  to dpram din_b, tied 0
ram_dout_b  in  DATA_WIDTH  from dpram dout_b

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr, rptr (ADDR_WIDTH+1 bits each), rd_pend, ob_cnt, both buffer entries and m_data clear to 0.
  - m_valid=0, s_ready=0, ram_we_a=0, count=0.
  - RAM contents are not cleared and are don't-care.
- Occupancy terms:
  - ram_occ = wptr - rptr (modulo 2**(ADDR_WIDTH+1)).
  - full = (ram_occ == DEPTH).
- Write side:
  - s_ready = rst_n & ~full.
  - push = s_valid & s_ready.
  - ram_we_a = push; ram_addr_a = wptr[ADDR_WIDTH-1:0]; ram_din_a = s_data.
  - wptr increments on push.
- Read issue:
  - ram_addr_b = rptr[ADDR_WIDTH-1:0] at all times.
  - pop = m_valid & m_ready.
  - rd_issue = (ram_occ != 0) & ((ob_cnt + rd_pend - pop) < 2).
  - On rd_issue: rptr increments and rd_pend is set to 1 next cycle; otherwise rd_pend is set to 0.
- Read capture:
  - When rd_pend=1, ram_dout_b is written into the output buffer tail.
  - ob_cnt updates by (+rd_pend - pop).
- Output:
  - m_valid = (ob_cnt != 0).
  - m_data = buffer head; the head advances on pop.
  - m_data is held stable while m_valid & ~m_ready.
  - A capture and a pop in the same cycle are both honoured.
- Read-during-write hazard:
  - The RAM returns old data when both ports hit one address on the same edge.
  - ram_occ uses registered wptr only, so a word written this cycle is never read this cycle. No bypass is required.
- Latency: a word accepted at edge E is written at E, read-issued in the following cycle, and captured at E+2. m_valid rises after edge E+2 when the FIFO was empty.
- Throughput: with m_ready=1 continuously and s_valid=1 continuously, after fill one word in and one word out per cycle, with no bubbles.
- Capacity: s_ready drops when the RAM holds DEPTH words. Total storage is DEPTH+2, and count reaches DEPTH+2 at most.
- count = ram_occ + rd_pend + ob_cnt, registered-term sum.
- Pointer wrap: pointers wrap naturally at 2**(ADDR_WIDTH+1). Full and empty are unambiguous via the extra MSB.
- Simultaneous push while full:
  - s_ready is 0, so no write occurs, even if a read issues in the same cycle.
  - s_ready rises the cycle after rptr advances.
- Reset mid-operation: all state clears immediately and any data in flight is discarded. The first push after rst_n rises is written at RAM address 0.

Test Plan:
- Reset, then single push of s_data=0xA5 at edge E with m_ready=1 -> ram_we_a=1, addr_a=0 in that cycle; m_valid=1 and m_data=0xA5 after edge E+2; count returns to 0 after the pop.
- m_ready=0, push 66 words 0..65 (ADDR_WIDTH=6) -> s_ready falls after the 64th RAM word with count=66; then m_ready=1 -> m_data yields 0..65 in order, one per cycle, with s_ready rising.
- Continuous s_valid=1, m_ready=1 for 200 words of incrementing data -> output equals input in order; after fill-up, m_valid stays high every cycle; pointers wrap past 127 correctly.
- Random s_valid/m_ready (50%) for 10k words -> scoreboard match, no drop or duplicate; m_data stable whenever m_valid & ~m_ready.
- Full FIFO, pop one word and present s_valid in the same cycle -> no write that cycle; write accepted the next cycle; count stays at 66 at most.
- Assert rst_n=0 mid-stream with count=10 -> m_valid=0, count=0, s_ready=0 immediately; after release, push 0x3C -> emerges as the next m_data with no stale words.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through stream FIFO controller wrapped around a simple
// dual-port RAM with registered reads. Port A writes, port B reads, and a
// 2-entry output buffer hides the one-cycle read latency so the FIFO can
// move one word per cycle in each direction.
module dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // upstream
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  // downstream
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  // occupancy
  output logic [ADDR_WIDTH:0]   count,
  // dpram port A (write)
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  // dpram port B (read)
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0]                  wptr, rptr, ram_occ;
  logic                           rd_pend;   // a RAM read is landing this cycle
  logic [1:0]                     ob_cnt;    // output buffer level, 0..2
  logic                           ob_hd;     // output buffer head index
  logic [1:0][DATA_WIDTH-1:0]     ob_mem;
  logic                           full, push, pop, rd_issue;
  logic [2:0]                     ob_lvl_nxt;

  // Occupancy uses registered wptr only: a word written this cycle is not
  // visible to the read side until next cycle, so no RAM bypass is needed.
  assign ram_occ = wptr - rptr;
  assign full    = (ram_occ == PW'(DEPTH));

  assign s_ready = rst_n & ~full;
  assign push    = s_valid & s_ready;
  assign m_valid = (ob_cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = ob_mem[ob_hd];

  // Buffer level next cycle if no new read is issued now. A read issued now
  // lands next cycle, so there must be a free slot for it then.
  assign ob_lvl_nxt = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_issue   = (ram_occ != '0) & (ob_lvl_nxt < 3'd2);

  assign ram_we_a   = push;
  assign ram_addr_a = wptr[ADDR_WIDTH-1:0];
  assign ram_din_a  = s_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rptr[ADDR_WIDTH-1:0];
  assign ram_din_b  = '0;

  assign count = ram_occ + PW'(rd_pend) + PW'(ob_cnt);

  // Write/read pointers; both wrap naturally at 2**PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)     wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;
    end
  end

  // One-deep read-in-flight flag tracking the RAM's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_issue;
  end

  // Output buffer: capture at the tail, retire from the head. Tail is head
  // when empty and the other slot when one word is held; capture never
  // happens with two words held because issue is throttled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_mem <= '0;
      ob_hd  <= 1'b0;
      ob_cnt <= 2'd0;
    end else begin
      if (rd_pend) ob_mem[ob_hd ^ ob_cnt[0]] <= ram_dout_b;
      if (pop)     ob_hd <= ~ob_hd;
      ob_cnt <= ob_lvl_nxt[1:0];
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural dpram beside the DUT, scoreboard
// queue filled on accepted pushes and drained by a monitor on every pop.
module tb_dpram_fifo_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0, m_data;
  logic [AW:0] count;
  logic ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_b;
  logic [DW-1:0] mem [2**AW];

  int total = 0, bad = 0;
  int cyc = 0, pops = 0, first_pop = -1, last_pop = -1;
  logic [DW-1:0] last_pop_data;
  logic [DW-1:0] q[$];
  logic held_v = 1'b0;
  logic [DW-1:0] held_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // simple dual-port RAM, registered read, old data on collision
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: handshakes are sampled mid-cycle, before the edge that takes them
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_v) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held_d);
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("unexpected_pop", m_data, 'hx);
        else chk("sb_data", m_data, q.pop_front());
        pops++;
        last_pop_data = m_data;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (s_valid && s_ready) q.push_back(s_data);
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while ((count != 0 || m_valid) && k < lim) begin tick; k++; end
    chk("drain_done", (count == 0 && !m_valid), 1);
  endtask

  task automatic phase_reset;
    pops = 0; first_pop = -1; last_pop = -1;
  endtask

  initial begin
    int n;
    // reset state
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_we_a", ram_we_a, 0);
    chk("rst_m_data", m_data, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // single word latency
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    #1;
    chk("t1_we_a", ram_we_a, 1);
    chk("t1_addr_a", ram_addr_a, 0);
    tick;                       // edge E
    s_valid = 1'b0;
    chk("t1_mv_e1", m_valid, 0);
    tick;                       // E+1
    chk("t1_mv_e1b", m_valid, 0);
    tick;                       // E+2
    chk("t1_mv_e2", m_valid, 1);
    chk("t1_md_e2", m_data, 8'hA5);
    tick;                       // E+3, popped
    chk("t1_count", count, 0);

    // fill to capacity with the consumer stalled
    m_ready = 1'b0; n = 0;
    for (int i = 0; i < 80; i++) begin
      s_valid = 1'b1; s_data = DW'(n);
      if (s_ready) n++;
      tick;
    end
    s_valid = 1'b0;
    chk("fill_words", n, 66);
    chk("fill_count", count, 66);
    chk("fill_s_ready", s_ready, 0);

    // full: pop one and offer a word in the same cycle
    phase_reset;
    s_valid = 1'b1; s_data = 8'd66; m_ready = 1'b1;
    #1;
    chk("full_no_we", ram_we_a, 0);
    chk("full_no_ready", s_ready, 0);
    tick;
    m_ready = 1'b0;
    chk("full_cnt_pop", count, 65);
    chk("full_ready_up", s_ready, 1);
    chk("full_we_next", ram_we_a, 1);
    tick;
    s_valid = 1'b0;
    chk("full_cnt_back", count, 66);

    // drain at full rate: no bubbles, words 1..66 in order
    phase_reset;
    m_ready = 1'b1;
    tick; tick;
    chk("drain_s_ready", s_ready, 1);
    drain(200);
    chk("drain_pops", pops, 66);
    chk("drain_span", last_pop - first_pop, 65);

    // streaming 200 words, pointers wrap past 127
    phase_reset;
    m_ready = 1'b1; n = 0;
    for (int i = 0; i < 400 && n < 200; i++) begin
      s_valid = 1'b1; s_data = DW'(n + 8'h40);
      if (s_ready) n++;
      tick;
    end
    s_valid = 1'b0;
    drain(50);
    chk("stream_pops", pops, 200);
    chk("stream_span", last_pop - first_pop, 199);

    // random valid/ready, 10k words
    phase_reset;
    n = 0;
    for (int i = 0; i < 60000 && n < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = DW'(n * 7 + 3);
      m_ready = 1'($urandom_range(0, 1));
      if (s_valid && s_ready) n++;
      tick;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    drain(200);
    chk("rand_pushes", n, 10000);
    chk("rand_pops", pops, 10000);

    // reset mid-stream with 10 words held
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = DW'(8'h10 + i);
      tick;
    end
    s_valid = 1'b0;
    tick; tick; tick;
    chk("mid_count", count, 10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mv", m_valid, 0);
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_rdy", s_ready, 0);
    q.delete();
    tick; tick;
    rst_n = 1'b1;
    tick;
    phase_reset;
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    #1;
    chk("post_addr_a", ram_addr_a, 0);
    chk("post_we_a", ram_we_a, 1);
    tick;
    s_valid = 1'b0;
    drain(20);
    chk("post_pops", pops, 1);
    chk("post_data", last_pop_data, 8'h3C);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
